m68k_bus_target: RTL and testbench
==================================

Name: m68k_bus_target

Overview:
- 68000 bus responder (slave) for the Amiga-side bus; the counterpart of the CPLD's bus-master sequencer.
- Decodes master cycles (AS/UDS/LDS/RW/A) against an address window and forwards hits to a local req/ack port (SRAM, register bank).
- Returns DTACK after a minimum wait count; drives read data onto M68K_D.

Parameters:
- BASE_ADDR, 23'h780000: window base, compared against A[23:1].
- ADDR_MASK, 23'h7F0000: bits of A[23:1] used in the compare; 1 means the bit is compared.
- WAIT_CYCLES, 2: minimum clocks from the local request to DTACK assertion. Range 0..15.
- TIMEOUT_CYCLES, 64: clocks without LOC_ACK before BERR. Used only with the optional feature.

Ports:
- M68K_CLK  in  1  bus clock; all logic is on the rising edge.
- RESET  in  1  asynchronous reset, active-high.
- M68K_A  in  23  address A[23:1].
- M68K_D  inout  16  data bus. Driven only during hit read cycles, otherwise z.
- M68K_AS_n  in  1  address strobe.
- M68K_UDS_n  in  1  upper data strobe.
- M68K_LDS_n  in  1  lower data strobe.
- M68K_RW  in  1  1 = read, 0 = write.
- M68K_DTACK_n  out  1  driven 0 to acknowledge, z otherwise.
- M68K_BERR_n  out  1  driven 0 on timeout, z otherwise (always z without the macro).
- LOC_REQ  out  1  local request, held until LOC_ACK.
- LOC_WE  out  1  local write enable.
- LOC_ADDR  out  23  latched A[23:1].
- LOC_BE  out  2  {~UDS_n, ~LDS_n} latched.
- LOC_WDATA  out  16  latched M68K_D for writes.
- LOC_RDATA  in  16  read data, valid with LOC_ACK.
- LOC_ACK  in  1  single-cycle completion pulse.
- HIT  out  1  registered; high from DECODE until the cycle ends.

Behaviour:
- Reset values: LOC_REQ=0, LOC_WE=0, LOC_ADDR=0, LOC_BE=0, LOC_WDATA=0, HIT=0, DTACK_n=z, BERR_n=z, M68K_D=z, state=IDLE, read latch=0.
- Input sampling: AS_n, UDS_n, LDS_n and RW are registered once on the rising edge.
- Decode: hit = ((A ^ BASE_ADDR) & ADDR_MASK) == 0.
- IDLE:
  - On sampled AS falling edge (previous sample 1, current 0) with hit: go to DECODE and set HIT.
  - A miss is ignored and the block stays silent for that cycle.
- DECODE, reads: with any DS low, latch A and BE, set LOC_REQ=1, LOC_WE=0, clear the wait counter, go to REQ.
- DECODE, writes: wait until a DS is sampled low (the write DS arrives late), then latch D into LOC_WDATA, set LOC_WE=1 and LOC_REQ=1, go to REQ.
- REQ:
  - Wait counter increments each clock.
  - On LOC_ACK: drop LOC_REQ and latch LOC_RDATA (reads).
  - Go to ACK once the ack has been seen and counter >= WAIT_CYCLES.
  - With WAIT_CYCLES=0, ACK is entered the clock after LOC_ACK.
- ACK:
  - DTACK_n=0.
  - M68K_D = read latch when RW=1 and AS_n=0.
  - Stay in ACK until AS_n is sampled high, then go to IDLE and clear HIT.
  - DTACK and the data bus release combinationally when raw AS_n=1 (no extra clock of drive into the next cycle).
- Aborted cycle (AS_n high while in DECODE or REQ):
  - From DECODE: go to IDLE.
  - From REQ with LOC_REQ still high: go to DRAIN, hold LOC_REQ until LOC_ACK, discard the result, then go to IDLE. DTACK is never asserted.
- Back-to-back cycles: a new cycle requires AS_n sampled high for at least one clock. A new AS falling edge while in DRAIN is latched as pending and serviced on DRAIN exit.
- LOC_ACK while LOC_REQ=0 is ignored.
- RESET mid-cycle: all outputs go to reset values immediately and the bus is released. Any outstanding local request is dropped without drain.

Optional Feature:
- Macro M68K_TARGET_BERR_EN.
- Defined:
  - A timeout counter runs in REQ. Reaching TIMEOUT_CYCLES without LOC_ACK drives BERR_n=0, drops LOC_REQ, and moves to state BERR.
  - BERR_n is released combinationally with AS_n high; the state then returns to IDLE.
  - DTACK is never asserted in a timed-out cycle.
- Undefined: no counter, BERR_n is constant z, and REQ waits indefinitely.

Decomposition:
- Package m68k_target_pkg:
  - State encodings IDLE, DECODE, REQ, ACK, DRAIN, BERR.
  - Width constants ADDR_W=23 and DATA_W=16.
  - Default BASE/MASK values.
- Sub-module m68k_addr_match: combinational window compare, reused by future targets.

Test Plan:
- Read word at A=23'h780010, LOC_ACK 1 clock after LOC_REQ, LOC_RDATA=16'hBEEF, WAIT_CYCLES=2 -> LOC_BE=2'b11, DTACK low 3 clocks after LOC_REQ, M68K_D=16'hBEEF until AS_n high, then z.
- Byte write, UDS only, D=16'h5A00 -> LOC_REQ only after UDS is sampled low, LOC_WE=1, LOC_BE=2'b10, LOC_WDATA=16'h5A00, DTACK asserted.
- Access at A=23'h000100 (miss) -> no LOC_REQ; DTACK_n, M68K_D and HIT stay z/0 for the whole cycle.
- AS_n raised 1 clock after LOC_REQ, LOC_ACK 4 clocks later -> DRAIN holds LOC_REQ until the ack, no DTACK; the next cycle is serviced normally.
- With M68K_TARGET_BERR_EN, TIMEOUT_CYCLES=64, no LOC_ACK -> BERR_n=0 on clock 64, LOC_REQ=0, released on AS_n high. Without the macro -> BERR_n stays z.
- RESET pulsed while in ACK -> DTACK_n and M68K_D go to z, LOC_REQ=0 and HIT=0 in the same cycle.

Source files
------------

// File: rtl/m68k_target_pkg.sv
// Shared types and constants for 68000 bus target blocks.
// Optional bus-error timeout is enabled in the top by M68K_TARGET_BERR_EN.
package m68k_target_pkg;
  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] DEF_BASE_ADDR = 23'h780000;
  localparam logic [ADDR_W-1:0] DEF_ADDR_MASK = 23'h7F0000;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    REQ,
    ACK,
    DRAIN,
    BERR
  } state_t;
endpackage

// File: rtl/m68k_addr_match.sv
// Combinational address-window compare: a mask bit of 1 means that A bit is compared.
module m68k_addr_match
  import m68k_target_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [ADDR_W-1:0] ADDR_MASK = DEF_ADDR_MASK
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit
);
  assign hit = ((addr ^ BASE_ADDR) & ADDR_MASK) == '0;
endmodule

// File: rtl/m68k_bus_target.sv
// 68000 bus responder: decodes master cycles into a local req/ack port and returns DTACK.
// Define M68K_TARGET_BERR_EN to add a LOC_ACK timeout that answers with BERR.
module m68k_bus_target
  import m68k_target_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR      = DEF_BASE_ADDR,
  parameter logic [ADDR_W-1:0] ADDR_MASK      = DEF_ADDR_MASK,
  parameter int                WAIT_CYCLES    = 2,
  parameter int                TIMEOUT_CYCLES = 64
) (
  input  logic              M68K_CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] M68K_A,
  inout  wire  [DATA_W-1:0] M68K_D,
  input  logic              M68K_AS_n,
  input  logic              M68K_UDS_n,
  input  logic              M68K_LDS_n,
  input  logic              M68K_RW,
  output wire               M68K_DTACK_n,
  output wire               M68K_BERR_n,
  output logic              LOC_REQ,
  output logic              LOC_WE,
  output logic [ADDR_W-1:0] LOC_ADDR,
  output logic [1:0]        LOC_BE,
  output logic [DATA_W-1:0] LOC_WDATA,
  input  logic [DATA_W-1:0] LOC_RDATA,
  input  logic              LOC_ACK,
  output logic              HIT
);
  localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

  state_t            state;
  logic              as_q, as_prev, uds_q, lds_q, rw_q;
  logic [3:0]        wait_cnt;
  logic              ack_seen;
  logic              pending;
  logic [DATA_W-1:0] rd_latch;
  logic              win_hit;
  logic              as_fall;
  logic              ds_any;
  logic              wait_done;
  logic              tmo_hit;

  m68k_addr_match #(
    .BASE_ADDR(BASE_ADDR),
    .ADDR_MASK(ADDR_MASK)
  ) u_match (
    .addr(M68K_A),
    .hit (win_hit)
  );

  assign as_fall   = as_prev & ~as_q;
  assign ds_any    = ~uds_q | ~lds_q;
  assign wait_done = ack_seen && (wait_cnt >= WAIT_C);

  // Bus drivers release on raw AS_n so nothing bleeds into the master's next cycle.
  assign M68K_DTACK_n = (state == ACK && !M68K_AS_n) ? 1'b0 : 1'bz;
  assign M68K_D = (state == ACK && !M68K_AS_n && M68K_RW && !LOC_WE) ? rd_latch : 'z;

`ifdef M68K_TARGET_BERR_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;

  always_ff @(posedge M68K_CLK or posedge RESET) begin
    if (RESET) tmo_cnt <= '0;
    else if (state == REQ) tmo_cnt <= tmo_cnt + 16'd1;
    else tmo_cnt <= '0;
  end

  assign tmo_hit     = (state == REQ) && !ack_seen && !LOC_ACK && (tmo_cnt == TMO_LAST);
  assign M68K_BERR_n = (state == BERR && !M68K_AS_n) ? 1'b0 : 1'bz;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
  assign M68K_BERR_n    = 1'bz;
`endif

  always_ff @(posedge M68K_CLK or posedge RESET) begin
    if (RESET) begin
      as_q      <= 1'b1;
      as_prev   <= 1'b1;
      uds_q     <= 1'b1;
      lds_q     <= 1'b1;
      rw_q      <= 1'b1;
      state     <= IDLE;
      LOC_REQ   <= 1'b0;
      LOC_WE    <= 1'b0;
      LOC_ADDR  <= '0;
      LOC_BE    <= '0;
      LOC_WDATA <= '0;
      HIT       <= 1'b0;
      wait_cnt  <= '0;
      ack_seen  <= 1'b0;
      pending   <= 1'b0;
      rd_latch  <= '0;
    end else begin
      as_q    <= M68K_AS_n;
      as_prev <= as_q;
      uds_q   <= M68K_UDS_n;
      lds_q   <= M68K_LDS_n;
      rw_q    <= M68K_RW;
      case (state)
        IDLE: if (as_fall && win_hit) begin
          state <= DECODE;
          HIT   <= 1'b1;
        end
        DECODE: begin
          if (as_q) begin
            state <= IDLE;
            HIT   <= 1'b0;
          end else if (ds_any) begin
            // Write data strobes arrive late, so this waits for them too.
            LOC_ADDR <= M68K_A;
            LOC_BE   <= {~uds_q, ~lds_q};
            LOC_WE   <= ~rw_q;
            if (!rw_q) LOC_WDATA <= M68K_D;
            LOC_REQ  <= 1'b1;
            wait_cnt <= '0;
            ack_seen <= 1'b0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;
          if (LOC_ACK && LOC_REQ) begin
            LOC_REQ  <= 1'b0;
            ack_seen <= 1'b1;
            if (!LOC_WE) rd_latch <= LOC_RDATA;
          end
          if (as_q) begin
            HIT     <= 1'b0;
            pending <= 1'b0;
            state   <= (LOC_REQ && !LOC_ACK) ? DRAIN : IDLE;
          end else if (tmo_hit) begin
            LOC_REQ <= 1'b0;
            state   <= BERR;
          end else if (wait_done) begin
            state <= ACK;
          end
        end
        ACK, BERR: if (as_q) begin
          state <= IDLE;
          HIT   <= 1'b0;
        end
        DRAIN: begin
          if (as_fall && win_hit) pending <= 1'b1;
          if (LOC_ACK) begin
            LOC_REQ <= 1'b0;
            pending <= 1'b0;
            if (pending || (as_fall && win_hit)) begin
              state <= DECODE;
              HIT   <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m68k_bus_target.sv
// Bench for m68k_bus_target: vector table of bus cycles plus abort, reset and timeout sequences.
module tb_m68k_bus_target;
  localparam int WAIT = 2;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [22:0] a = '0;
  logic        as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
  logic [15:0] loc_rdata = '0;
  logic        loc_ack = 1'b0;
  logic [15:0] tb_d = '0;
  logic        tb_d_oe = 1'b0;
  tri1  [15:0] d_bus;
  tri1         dtack_n, berr_n;
  logic        loc_req, loc_we, hit;
  logic [22:0] loc_addr;
  logic [1:0]  loc_be;
  logic [15:0] loc_wdata;

  assign d_bus = tb_d_oe ? tb_d : 'z;

  m68k_bus_target #(
    .WAIT_CYCLES(WAIT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .M68K_CLK(clk), .RESET(rst), .M68K_A(a), .M68K_D(d_bus),
    .M68K_AS_n(as_n), .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw),
    .M68K_DTACK_n(dtack_n), .M68K_BERR_n(berr_n),
    .LOC_REQ(loc_req), .LOC_WE(loc_we), .LOC_ADDR(loc_addr), .LOC_BE(loc_be),
    .LOC_WDATA(loc_wdata), .LOC_RDATA(loc_rdata), .LOC_ACK(loc_ack), .HIT(hit)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: {we, addr, be, wdata} per expected local request
  logic [41:0] exp_q[$];
  int          ack_dly = 1;
  logic [15:0] rsp_data = '0;
  int          req_cyc = 0;

  initial begin : responder
    logic req_prev;
    logic [41:0] e;
    req_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (loc_req && !req_prev && !rst) begin
        req_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_req", {41'd0, loc_req}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("req_we",   {63'd0, loc_we}, {63'd0, e[41]});
          check("req_addr", {41'd0, loc_addr}, {41'd0, e[40:18]});
          check("req_be",   {62'd0, loc_be}, {62'd0, e[17:16]});
          if (e[41]) check("req_wdata", {48'd0, loc_wdata}, {48'd0, e[15:0]});
        end
        if (ack_dly > 0) begin
          repeat (ack_dly - 1) begin @(posedge clk); #1; end
          loc_rdata = rsp_data;
          loc_ack = 1'b1;
          @(posedge clk); #1;
          loc_ack = 1'b0;
        end
      end
      req_prev = loc_req;
    end
  end

  // driver: one complete master cycle with its expectations
  task automatic bus_cycle(input logic [22:0] addr, input logic rd, input logic [1:0] be,
                           input logic [15:0] wd, input logic [15:0] rdata, input int adly,
                           input logic exp_hit);
    bit got;
    bit silent;
    int exp_lat;
    ack_dly  = adly;
    rsp_data = rdata;
    @(negedge clk);
    a = addr;
    rw = rd;
    if (!rd) begin tb_d = wd; tb_d_oe = 1'b1; end
    if (exp_hit) exp_q.push_back({~rd, addr, be, wd});
    as_n = 1'b0;
    if (rd) begin uds_n = ~be[1]; lds_n = ~be[0]; end
    else begin
      repeat (3) @(negedge clk);
      if (exp_hit) check("write_req_before_ds", {63'd0, loc_req}, 64'd0);
      uds_n = ~be[1]; lds_n = ~be[0];
    end
    if (exp_hit) begin
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (dtack_n === 1'b0) got = 1'b1;
      end
      check("dtack_seen", {63'd0, got}, 64'd1);
      exp_lat = ((adly > WAIT) ? adly : WAIT) + 1;
      check("dtack_latency", 64'(cyc - req_cyc), 64'(exp_lat));
      check("hit_during_ack", {63'd0, hit}, 64'd1);
      if (rd) check("read_data", {48'd0, d_bus}, {48'd0, rdata});
      @(negedge clk);
      check("dtack_hold", {63'd0, dtack_n}, 64'd0);
    end else begin
      silent = 1'b1;
      repeat (8) begin
        @(negedge clk);
        if (dtack_n !== 1'b1 || hit !== 1'b0 || loc_req !== 1'b0) silent = 1'b0;
        if (rd && d_bus !== 16'hFFFF) silent = 1'b0;
      end
      check("miss_silent", {63'd0, silent}, 64'd1);
    end
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; tb_d_oe = 1'b0;
    #1;
    check("dtack_release", {63'd0, dtack_n}, 64'd1);
    check("data_release", {48'd0, d_bus}, 64'hFFFF);
    repeat (2) @(negedge clk);
    check("hit_clear", {63'd0, hit}, 64'd0);
  endtask

  typedef struct {
    logic [22:0] addr;
    logic        rd;
    logic [1:0]  be;
    logic [15:0] wd;
    logic [15:0] rdata;
    int          adly;
    logic        hit;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit seen;
    bit no_dtack;
    vecs[0] = '{23'h780010, 1'b1, 2'b11, 16'h0000, 16'hBEEF, 1, 1'b1};
    vecs[1] = '{23'h780020, 1'b0, 2'b10, 16'h5A00, 16'h0000, 1, 1'b1};
    vecs[2] = '{23'h000100, 1'b1, 2'b11, 16'h0000, 16'h1111, 1, 1'b0};
    vecs[3] = '{23'h78FFFF, 1'b1, 2'b01, 16'h0000, 16'h1234, 3, 1'b1};
    vecs[4] = '{23'h77FFFF, 1'b0, 2'b11, 16'hA5A5, 16'h0000, 1, 1'b0};
    vecs[5] = '{23'h780000, 1'b0, 2'b01, 16'h00C3, 16'h0000, 2, 1'b1};
    vecs[6] = '{23'h790000, 1'b1, 2'b11, 16'h0000, 16'h2222, 1, 1'b0};
    vecs[7] = '{23'h781234, 1'b1, 2'b10, 16'h0000, 16'h8001, 5, 1'b1};
    vecs[8] = '{23'h7F0000, 1'b1, 2'b11, 16'h0000, 16'h3333, 1, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_loc_req",   {63'd0, loc_req}, 64'd0);
    check("rst_loc_we",    {63'd0, loc_we}, 64'd0);
    check("rst_loc_addr",  {41'd0, loc_addr}, 64'd0);
    check("rst_loc_be",    {62'd0, loc_be}, 64'd0);
    check("rst_loc_wdata", {48'd0, loc_wdata}, 64'd0);
    check("rst_hit",       {63'd0, hit}, 64'd0);
    check("rst_dtack",     {63'd0, dtack_n}, 64'd1);
    check("rst_berr",      {63'd0, berr_n}, 64'd1);
    check("rst_data",      {48'd0, d_bus}, 64'hFFFF);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++)
      bus_cycle(vecs[i].addr, vecs[i].rd, vecs[i].be, vecs[i].wd, vecs[i].rdata,
                vecs[i].adly, vecs[i].hit);

    for (int i = 0; i < 6; i++)
      bus_cycle({7'h78, 16'($urandom_range(0, 65535))}, 1'($urandom_range(0, 1)),
                2'($urandom_range(1, 3)), 16'($urandom_range(0, 65535)),
                16'($urandom_range(0, 65535)), $urandom_range(1, 4), 1'b1);

    // abort one clock after the request; the local side acks late and is drained
    ack_dly = 5;
    @(negedge clk);
    a = 23'h780040; rw = 1'b1;
    exp_q.push_back({1'b0, 23'h780040, 2'b11, 16'h0000});
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (loc_req === 1'b1) seen = 1'b1;
    end
    check("abort_req_seen", {63'd0, seen}, 64'd1);
    no_dtack = 1'b1;
    @(negedge clk);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (dtack_n !== 1'b1) no_dtack = 1'b0;
    end
    check("drain_holds_req", {63'd0, loc_req}, 64'd1);
    @(negedge clk);
    check("drain_req_dropped", {63'd0, loc_req}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      if (dtack_n !== 1'b1) no_dtack = 1'b0;
    end
    check("abort_no_dtack", {63'd0, no_dtack}, 64'd1);
    bus_cycle(23'h780042, 1'b1, 2'b11, 16'h0000, 16'h6C6C, 2, 1'b1);

    // reset while DTACK is asserted
    ack_dly = 1;
    rsp_data = 16'h4321;
    @(negedge clk);
    a = 23'h780050; rw = 1'b1;
    exp_q.push_back({1'b0, 23'h780050, 2'b11, 16'h0000});
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (dtack_n === 1'b0) seen = 1'b1;
    end
    check("rst_ack_reached", {63'd0, seen}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst_ack_dtack", {63'd0, dtack_n}, 64'd1);
    check("rst_ack_data",  {48'd0, d_bus}, 64'hFFFF);
    check("rst_ack_req",   {63'd0, loc_req}, 64'd0);
    check("rst_ack_hit",   {63'd0, hit}, 64'd0);
    @(negedge clk);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // local side never acknowledges
    ack_dly = 0;
    @(negedge clk);
    a = 23'h780060; rw = 1'b1;
    exp_q.push_back({1'b0, 23'h780060, 2'b11, 16'h0000});
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (loc_req === 1'b1) seen = 1'b1;
    end
    check("noack_req_seen", {63'd0, seen}, 64'd1);
`ifdef M68K_TARGET_BERR_EN
    repeat (TMO - 1) @(negedge clk);
    check("berr_not_early", {63'd0, berr_n}, 64'd1);
    @(negedge clk);
    check("berr_asserted", {63'd0, berr_n}, 64'd0);
    check("berr_req_drop", {63'd0, loc_req}, 64'd0);
    check("berr_no_dtack", {63'd0, dtack_n}, 64'd1);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    #1;
    check("berr_release", {63'd0, berr_n}, 64'd1);
    repeat (3) @(negedge clk);
`else
    no_dtack = 1'b1;
    repeat (TMO + 16) begin
      @(negedge clk);
      if (berr_n !== 1'b1 || dtack_n !== 1'b1) no_dtack = 1'b0;
    end
    check("noberr_silent", {63'd0, no_dtack}, 64'd1);
    check("noberr_req_held", {63'd0, loc_req}, 64'd1);
    rst = 1'b1;
    #1;
    check("noberr_rst_req", {63'd0, loc_req}, 64'd0);
    @(negedge clk);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
`endif
    bus_cycle(23'h780070, 1'b0, 2'b11, 16'h9ABC, 16'h0000, 1, 1'b1);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
